// File: rtl/ttl_select_arbiter_pkg.sv
// Shared definitions for the select-line arbiter.
//   state_t   : arbiter states, 2-bit encoding (IDLE, GRANT, RELEASE)
//   wrap_inc  : increments an index and wraps to zero after n-1, using an
//               explicit compare so that non-power-of-2 widths also work
package ttl_select_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ttl_74138.sv
// 3-to-8 style active-low line decoder, generalised to WIDTH_OUT outputs.
//   Enable1_bar, Enable2_bar : active-low enables (both must be 0)
//   Enable3                  : active-high enable
//   A                        : address of the output to pull low
//   Y                        : one-cold active-low outputs; all 1s when disabled
// DELAY_RISE / DELAY_FALL describe the edge delays of the discrete part. This
// model is zero-delay logic, so they are only sanity-checked here.
module ttl_74138 #(
  parameter int WIDTH_OUT  = 8,
  parameter int WIDTH_IN   = $clog2(WIDTH_OUT),
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                 Enable1_bar,
  input  logic                 Enable2_bar,
  input  logic                 Enable3,
  input  logic [WIDTH_IN-1:0]  A,
  output logic [WIDTH_OUT-1:0] Y
);

  logic enabled;

  // Negative delays make no sense for a physical part; the empty block marks
  // the configuration without affecting the logic.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay_params
  end

  assign enabled = !Enable1_bar && !Enable2_bar && Enable3;

  always_comb begin
    Y = '1;
    // Addresses past the last line (non-power-of-2 widths) select nothing.
    if (enabled && (int'(A) < WIDTH_OUT)) begin
      Y[A] = 1'b0;
    end
  end

endmodule

// File: rtl/ttl_select_arbiter.sv
// Round-robin arbiter sharing one active-low select decoder among WIDTH_OUT
// requesters. A winner's select is held low for at most HOLD_CYCLES cycles,
// then one dead cycle with all selects high guarantees selects never overlap.
//   clk       : rising-edge clock
//   reset_bar : asynchronous active-low reset
//   req       : level request, bit i = requester i
//   sel_bar   : one-cold active-low select, always the decoder output
//   addr      : index of the current / most recent grant
//   busy      : high while granting or releasing
//   done      : one-cycle pulse in the first (and only) RELEASE cycle
module ttl_select_arbiter
  import ttl_select_arbiter_pkg::*;
#(
  parameter int WIDTH_OUT   = 8,
  parameter int WIDTH_IN    = $clog2(WIDTH_OUT),
  parameter int HOLD_CYCLES = 2,
  parameter int DELAY_RISE  = 0,
  parameter int DELAY_FALL  = 0
) (
  input  logic                 clk,
  input  logic                 reset_bar,
  input  logic [WIDTH_OUT-1:0] req,
  output logic [WIDTH_OUT-1:0] sel_bar,
  output logic [WIDTH_IN-1:0]  addr,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_t              state, state_nxt;
  logic [WIDTH_IN-1:0] ptr, ptr_nxt;
  logic [WIDTH_IN-1:0] addr_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                done_nxt;
  logic [WIDTH_IN-1:0] winner;
  logic                found;

  // Rotating priority scan: start at ptr and walk upward with wrap, first set
  // request wins. The wrap is an explicit subtract so addr stays in range.
  always_comb begin : scan
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < WIDTH_OUT; k++) begin
      idx = int'(ptr) + k;
      if (idx >= WIDTH_OUT) begin
        idx = idx - WIDTH_OUT;
      end
      if (!found && req[WIDTH_IN'(idx)]) begin
        found  = 1'b1;
        winner = WIDTH_IN'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          addr_nxt  = winner;
          cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A dropped request ends the grant immediately; otherwise it runs
        // until the hold budget is used up. The winner becomes lowest
        // priority for the next scan.
        if (!req[addr] || cnt == '0) begin
          state_nxt = ST_RELEASE;
          done_nxt  = 1'b1;
          ptr_nxt   = WIDTH_IN'(wrap_inc(int'(addr), WIDTH_OUT));
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state <= ST_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      addr  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      addr  <= addr_nxt;
      done  <= done_nxt;
    end
  end

  assign busy = (state != ST_IDLE);

  // The decoder is enabled only while granting, so RELEASE and IDLE drive all
  // selects high and reset clears them without waiting for a clock.
  ttl_74138 #(
    .WIDTH_OUT  (WIDTH_OUT),
    .WIDTH_IN   (WIDTH_IN),
    .DELAY_RISE (DELAY_RISE),
    .DELAY_FALL (DELAY_FALL)
  ) u_decoder (
    .Enable1_bar (1'b0),
    .Enable2_bar (1'b0),
    .Enable3     (state == ST_GRANT),
    .A           (addr),
    .Y           (sel_bar)
  );

endmodule

// File: tb/tb_ttl_select_arbiter.sv
module tb_ttl_select_arbiter;

  localparam int N     = 8;
  localparam int HOLD  = 2;
  localparam int BOUND = N * (HOLD + 2);

  logic         clk;
  logic         reset_bar;
  logic [N-1:0] req;
  logic [N-1:0] sel_bar;
  logic [2:0]   addr;
  logic         busy;
  logic         done;

  int compared;
  int mismatched;

  typedef struct {
    logic [N-1:0] sel;
    logic [2:0]   addr;
    logic         busy;
    logic         done;
  } exp_t;

  typedef struct {
    int owner;
    int len;
  } grant_t;

  exp_t   exp_q[$];
  grant_t gnt_q[$];
  int     grant_log[$];
  int     len_log[$];

  ttl_select_arbiter #(
    .WIDTH_OUT   (N),
    .WIDTH_IN    (3),
    .HOLD_CYCLES (HOLD),
    .DELAY_RISE  (0),
    .DELAY_FALL  (0)
  ) dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .req       (req),
    .sel_bar   (sel_bar),
    .addr      (addr),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: time-based view of the arbitration rules. owner is the
  // requester currently holding its select (-1 none), held counts cycles it
  // has been low, cool counts remaining dead cycles before the next scan.
  int   m_owner, m_held, m_cool, m_ptr, m_addr;
  logic m_done;

  always @(posedge clk or negedge reset_bar) begin
    exp_t e;
    if (!reset_bar) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_ptr = 0; m_addr = 0;
      exp_q.delete();
      gnt_q.delete();
      e = '{sel: 8'hFF, addr: 3'd0, busy: 1'b0, done: 1'b0};
      exp_q.push_back(e);
    end else begin
      m_done = 1'b0;
      if (m_cool > 0) begin
        m_cool--;
      end else if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (m_owner < 0 && req[c]) m_owner = c;
        end
        if (m_owner >= 0) begin
          m_held = 1;
          m_addr = m_owner;
        end
      end else if (!req[m_owner] || m_held == HOLD) begin
        gnt_q.push_back('{owner: m_owner, len: m_held});
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cool  = 1;
        m_done  = 1'b1;
      end else begin
        m_held++;
      end
      e.sel  = (m_owner >= 0) ? ~(8'd1 << m_owner) : 8'hFF;
      e.addr = 3'(m_addr);
      e.busy = (m_owner >= 0) || (m_cool > 0);
      e.done = m_done;
      exp_q.push_back(e);
    end
  end

  // Monitor: pops one expectation per cycle, checks invariants, and logs each
  // completed grant when done is seen.
  logic [N-1:0] prev_sel;
  int           run, last_run;
  int           wt[N];

  always @(negedge clk) begin
    exp_t   e;
    grant_t g;
    int     worst;
    if (exp_q.size() == 0) begin
      if (reset_bar) begin
        compared++;
        mismatched++;
        $display("FAIL sb_underflow: got no expectation at %0t", $time);
      end
    end else begin
      e = exp_q.pop_front();
      chk("sel_bar", int'(sel_bar), int'(e.sel));
      chk("addr", int'(addr), int'(e.addr));
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
    end
    if (!reset_bar) begin
      prev_sel = 8'hFF;
      run      = 0;
      last_run = 0;
      for (int i = 0; i < N; i++) wt[i] = 0;
    end else begin
      chk("one_cold", ($countones(~sel_bar) <= 1) ? 1 : 0, 1);
      if (prev_sel != 8'hFF && sel_bar != 8'hFF)
        chk("dead_cycle", int'(sel_bar), int'(prev_sel));
      prev_sel = sel_bar;
      if (sel_bar != 8'hFF) begin
        run++;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      if (done) begin
        grant_log.push_back(int'(addr));
        len_log.push_back(last_run);
        if (gnt_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL grant_unexpected: got addr %0d expected none", addr);
        end else begin
          g = gnt_q.pop_front();
          chk("grant_addr", int'(addr), g.owner);
          chk("grant_len", last_run, g.len);
        end
      end
      worst = 0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && sel_bar[i]) wt[i]++;
        else wt[i] = 0;
        if (wt[i] > worst) worst = wt[i];
      end
      compared++;
      if (worst > BOUND) begin
        mismatched++;
        $display("FAIL starvation: got wait %0d expected <= %0d", worst, BOUND);
      end
    end
  end

  task automatic wait_grants(input int n, input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (grant_log.size() < n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    compared++;
    if (grant_log.size() < n) begin
      mismatched++;
      $display("FAIL %s_timeout: got %0d grants expected %0d", tag, grant_log.size(), n);
    end
  endtask

  task automatic wait_sel(input logic [N-1:0] v, input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (sel_bar != v && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_sel"}, int'(sel_bar), int'(v));
  endtask

  task automatic check_log(input int idx, input int expv, input string tag);
    if (idx >= grant_log.size()) chk({tag, "_missing"}, grant_log.size(), idx + 1);
    else chk(tag, grant_log[idx], expv);
  endtask

  task automatic check_len(input int idx, input int expv, input string tag);
    if (idx >= len_log.size()) chk({tag, "_missing"}, len_log.size(), idx + 1);
    else chk(tag, len_log[idx], expv);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    len_log.delete();
  endtask

  initial begin
    logic [N-1:0] m;
    compared   = 0;
    mismatched = 0;
    reset_bar  = 1'b0;
    req        = '0;
    repeat (2) @(posedge clk);
    #1 reset_bar = 1'b1;

    // Single persistent requester: two full grants with a dead cycle between.
    clear_logs();
    req = 8'h08;
    wait_grants(2, 40, "single");
    check_log(0, 3, "single_g0");
    check_log(1, 3, "single_g1");
    check_len(0, HOLD, "single_len0");
    check_len(1, HOLD, "single_len1");
    req = '0;
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a grant.
    req = 8'h04;
    wait_sel(8'hFB, 20, "rst_pre");
    #2 reset_bar = 1'b0;
    #1;
    chk("rst_sel", int'(sel_bar), 8'hFF);
    chk("rst_addr", int'(addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1 reset_bar = 1'b1;
    clear_logs();
    wait_grants(1, 40, "rst_post");
    check_log(0, 2, "rst_first_grant");
    req = '0;
    repeat (4) @(posedge clk);
    #2 reset_bar = 1'b0;
    @(posedge clk); #1 reset_bar = 1'b1;

    // Round robin with every requester active.
    clear_logs();
    req = 8'hFF;
    wait_grants(9, 100, "rr");
    for (int i = 0; i < 9; i++) check_log(i, i % N, "rr_order");
    check_len(0, HOLD, "rr_len0");
    check_len(7, HOLD, "rr_len7");
    req = '0;
    repeat (6) @(posedge clk);
    #1;

    // Pointer wrap: after granting 6 the pointer is 7, so 0 beats 6.
    clear_logs();
    req = 8'h40;
    wait_grants(1, 40, "wrap_pre");
    check_log(0, 6, "wrap_pre_grant");
    req = 8'h41;
    clear_logs();
    wait_grants(2, 40, "wrap");
    check_log(0, 0, "wrap_g0");
    check_log(1, 6, "wrap_g1");

    // Early drop after one grant cycle, then pointer must sit at 4.
    clear_logs();
    req = 8'h08;
    wait_sel(8'hF7, 20, "drop_pre");
    req = '0;
    wait_grants(1, 20, "drop");
    check_log(0, 3, "drop_grant");
    check_len(0, 1, "drop_len");
    clear_logs();
    req = 8'h18;
    wait_grants(1, 40, "drop_next");
    check_log(0, 4, "drop_ptr");
    req = '0;
    repeat (6) @(posedge clk);
    #1;

    // Random slowly-changing requests.
    clear_logs();
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      m = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) m[b] = 1'b1;
      req = req ^ m;
    end
    compared++;
    if (grant_log.size() < 100) begin
      mismatched++;
      $display("FAIL random_activity: got %0d grants expected >= 100", grant_log.size());
    end
    req = '0;
    repeat (10) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
